// File: rtl/assoc_search_if.sv
// ============================================================================
// Module  : assoc_search_if
// Brief   : Query/class/result bundle between the HDC encoder side and the
//           associative-memory search stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface assoc_search_if #(
    parameter int HV_DIM      = 64,
    parameter int CLASS_COUNT = 4
);
    localparam int CLASS_W = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
    localparam int SCORE_W = $clog2(HV_DIM + 1);

    logic                                en;
    logic                                start_search;
    logic [HV_DIM-1:0]                   encoded_HV;
    logic [CLASS_COUNT-1:0][HV_DIM-1:0]  class_HVs;
    logic                                busy;
    logic                                search_done;
    logic [CLASS_W-1:0]                  predicted_class;
    logic [SCORE_W-1:0]                  best_score;

    modport master (
        output en, start_search, encoded_HV, class_HVs,
        input  busy, search_done, predicted_class, best_score
    );

    modport slave (
        input  en, start_search, encoded_HV, class_HVs,
        output busy, search_done, predicted_class, best_score
    );
endinterface

`default_nettype wire

// File: rtl/assoc_search.sv
// ============================================================================
// Module  : assoc_search
// Brief   : Sequential argmax of popcount(query & class_HV) over the stored
//           classes, one class per enabled cycle, with a one-cycle done pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module assoc_search #(
    parameter int HV_DIM      = 64,
    parameter int CLASS_COUNT = 4
) (
    input  wire logic       clk,
    input  wire logic       nrst,
    assoc_search_if.slave   bus
);
    localparam int CLASS_W = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
    localparam int SCORE_W = $clog2(HV_DIM + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    localparam logic [CLASS_W-1:0] c_LAST_IDX = CLASS_W'(CLASS_COUNT - 1);

    logic [0:0]          r_state;
    logic [HV_DIM-1:0]   r_query;
    logic [CLASS_W-1:0]  r_idx;
    logic [SCORE_W-1:0]  r_run_score;
    logic [CLASS_W-1:0]  r_run_class;
    logic                r_busy;
    logic                r_done;
    logic [CLASS_W-1:0]  r_pred_class;
    logic [SCORE_W-1:0]  r_best_score;

    logic [HV_DIM-1:0]   w_and;
    logic [SCORE_W-1:0]  w_score;
    logic                w_take;
    logic [SCORE_W-1:0]  w_win_score;
    logic [CLASS_W-1:0]  w_win_class;

    always_comb begin
        w_and   = r_query & bus.class_HVs[r_idx];
        w_score = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            w_score = w_score + SCORE_W'(w_and[i]);
        end
        // Strict compare keeps the lowest index on ties; idx 0 always seeds.
        w_take      = (r_idx == '0) || (w_score > r_run_score);
        w_win_score = w_take ? w_score : r_run_score;
        w_win_class = w_take ? r_idx   : r_run_class;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_query      <= '0;
            r_idx        <= '0;
            r_run_score  <= '0;
            r_run_class  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pred_class <= '0;
            r_best_score <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    S_IDLE: begin
                        // A start coinciding with the done pulse is dropped.
                        if (bus.start_search && !r_done) begin
                            r_query     <= bus.encoded_HV;
                            r_idx       <= '0;
                            r_run_score <= '0;
                            r_run_class <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        r_run_score <= w_win_score;
                        r_run_class <= w_win_class;
                        if (r_idx == c_LAST_IDX) begin
                            r_pred_class <= w_win_class;
                            r_best_score <= w_win_score;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + CLASS_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy            = r_busy;
    assign bus.search_done     = r_done;
    assign bus.predicted_class = r_pred_class;
    assign bus.best_score      = r_best_score;

endmodule

`default_nettype wire

// File: tb/tb_assoc_search.sv
// ============================================================================
// Module  : tb_assoc_search
// Brief   : Self-checking bench for assoc_search: directed vector table,
//           multi-cycle corner sequences and random sets against a golden model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_assoc_search;
    localparam int HV_DIM      = 64;
    localparam int CLASS_COUNT = 4;

    typedef logic [CLASS_COUNT-1:0][HV_DIM-1:0] classes_t;

    typedef struct {
        string       name;
        logic [63:0] q;
        classes_t    c;
        int          stall_at;
        int          stall_len;
        int          exp_cls;
        int          exp_score;
        int          exp_cyc;
    } vec_t;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    assoc_search_if #(.HV_DIM(HV_DIM), .CLASS_COUNT(CLASS_COUNT)) bus ();

    assoc_search #(.HV_DIM(HV_DIM), .CLASS_COUNT(CLASS_COUNT)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: software argmax of overlaps, first maximum wins.
    function automatic void golden(input logic [63:0] q, input classes_t c,
                                   output int cls, output int sc);
        cls = 0;
        sc  = -1;
        for (int k = 0; k < CLASS_COUNT; k++) begin
            int s;
            s = $countones(q & c[k]);
            if (s > sc) begin
                sc  = s;
                cls = k;
            end
        end
    endfunction

    task automatic run_search(input logic [63:0] q, input classes_t c,
                              input int stall_at, input int stall_len,
                              output int cls, output int sc, output int cyc);
        bus.encoded_HV   = q;
        bus.class_HVs    = c;
        bus.en           = 1'b1;
        bus.start_search = 1'b1;
        tick();
        bus.start_search = 1'b0;
        bus.encoded_HV   = ~q;
        cyc = 0;
        while (!bus.search_done && cyc < 50) begin
            bus.en = (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : 1'b1;
            tick();
            cyc++;
        end
        bus.en = 1'b1;
        if (!bus.search_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_50");
        end
        cls = int'(bus.predicted_class);
        sc  = int'(bus.best_score);
    endtask

    vec_t vecs[6];

    initial begin
        int       cls, sc, cyc, dones, gcls, gsc;
        classes_t c;
        logic [63:0] qa, qb;

        checks = 0;
        errors = 0;

        vecs[0] = '{"distinct", 64'h00FF_00FF_00FF_00FF,
                    {64'h0000_0000_0000_000F, 64'h00FF_00FF_00FF_00FF,
                     64'hFFFF_0000_0000_0000, 64'h0},
                    0, 0, 2, 32, 4};
        vecs[1] = '{"tie", 64'hF,
                    {64'hF, 64'h0, 64'hF, 64'h0},
                    0, 0, 1, 4, 4};
        vecs[2] = '{"stall", 64'h00FF_00FF_00FF_00FF,
                    {64'h0000_0000_0000_000F, 64'h00FF_00FF_00FF_00FF,
                     64'hFFFF_0000_0000_0000, 64'h0},
                    2, 3, 2, 32, 7};
        vecs[3] = '{"zero_query", 64'h0,
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
                     64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555},
                    0, 0, 0, 0, 4};
        vecs[4] = '{"full_score", 64'hFFFF_FFFF_FFFF_FFFF,
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                     64'h0000_FFFF_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFE},
                    0, 0, 3, 64, 4};
        vecs[5] = '{"zero_classes", 64'hDEAD_BEEF_CAFE_F00D,
                    {64'h0, 64'h0, 64'h0, 64'h0},
                    0, 0, 0, 0, 4};

        bus.en           = 1'b1;
        bus.start_search = 1'b0;
        bus.encoded_HV   = '0;
        bus.class_HVs    = '0;
        nrst             = 1'b0;
        tick();
        tick();
        check("reset_busy",  bus.busy, 0);
        check("reset_done",  bus.search_done, 0);
        check("reset_class", bus.predicted_class, 0);
        check("reset_score", bus.best_score, 0);
        nrst = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_search(vecs[v].q, vecs[v].c, vecs[v].stall_at, vecs[v].stall_len, cls, sc, cyc);
            check({vecs[v].name, "_latency"}, cyc, vecs[v].exp_cyc);
            check({vecs[v].name, "_class"}, cls, vecs[v].exp_cls);
            check({vecs[v].name, "_score"}, sc, vecs[v].exp_score);
            // Start during the done cycle must be dropped.
            bus.start_search = (v == 0);
            tick();
            bus.start_search = 1'b0;
            check({vecs[v].name, "_done_pulse_width"}, bus.search_done, 0);
            check({vecs[v].name, "_busy_after"}, bus.busy, 0);
            tick();
        end

        // Busy-ignore: a second start one cycle later with another query.
        qa = 64'h00FF_00FF_00FF_00FF;
        qb = 64'hFFFF_0000_0000_0000;
        c  = {64'h0000_0000_0000_000F, 64'h00FF_00FF_00FF_00FF,
              64'hFFFF_0000_0000_0000, 64'h0};
        golden(qa, c, gcls, gsc);
        bus.class_HVs    = c;
        bus.encoded_HV   = qa;
        bus.start_search = 1'b1;
        tick();
        bus.encoded_HV = qb;
        tick();
        bus.start_search = 1'b0;
        dones = 0;
        for (int t = 0; t < 12; t++) begin
            if (bus.search_done) begin
                dones++;
                check("busy_ignore_class", bus.predicted_class, gcls);
                check("busy_ignore_score", bus.best_score, gsc);
            end
            tick();
        end
        check("busy_ignore_done_count", dones, 1);
        check("busy_ignore_busy_after", bus.busy, 0);

        // Reset in the middle of a scan aborts it and clears the result.
        bus.encoded_HV   = qa;
        bus.start_search = 1'b1;
        tick();
        bus.start_search = 1'b0;
        tick();
        nrst = 1'b0;
        tick();
        tick();
        check("midreset_busy",  bus.busy, 0);
        check("midreset_done",  bus.search_done, 0);
        check("midreset_class", bus.predicted_class, 0);
        check("midreset_score", bus.best_score, 0);
        nrst  = 1'b1;
        dones = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.search_done) dones++;
        end
        check("midreset_no_done", dones, 0);

        // Random sets driven like encoding_done pulses.
        for (int n = 0; n < 20; n++) begin
            qa = rand64() & rand64();
            for (int k = 0; k < CLASS_COUNT; k++) begin
                case ($urandom_range(0, 3))
                    0:       c[k] = rand64() & rand64();
                    1:       c[k] = qa;
                    2:       c[k] = '0;
                    default: c[k] = rand64();
                endcase
            end
            golden(qa, c, gcls, gsc);
            run_search(qa, c, 0, 0, cls, sc, cyc);
            check($sformatf("rand%0d_class", n), cls, gcls);
            check($sformatf("rand%0d_score", n), sc, gsc);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
